vscale_wb_htif_bridge: RTL and testbench

Wishbone B3 classic slave that lets an SoC master (debug UART, boot ROM loader, testbench host) issue HTIF PCR reads and writes into the vscale CSR file. Typical targets are to_host and from_host. It sits directly upstream of the CSR file's htif_pcr_req_* / htif_pcr_resp_* ports. The bridge converts register-mapped commands into a single outstanding PCR transaction, with a response capture, a timeout and a completion interrupt.

---
 rtl/vscale_wb_htif_bridge.sv | 171 +++++++++++++++++
 tb/tb_vscale_wb_htif_bridge.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_wb_htif_bridge.sv
// Wishbone B3 classic slave that issues one HTIF PCR read/write at a time into the vscale CSR file.
// Latency: wb_ack_o one cycle after cyc&stb (one wait state); PCR request presented the cycle after the go write.
// Backpressure: req_valid is held until req_ready; each PCR phase aborts after TIMEOUT_CYCLES with timeout+done.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   wb_*                       Wishbone slave (word offsets from wb_adr_i[4:2])
//   irq_o                      level interrupt = done & irq_en
//   htif_reset                 reset delayed by one register stage
//   htif_pcr_req_* / resp_*    PCR request/response handshake towards the CSR file
module vscale_wb_htif_bridge #(
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int HTIF_PCR_WIDTH = 64,   // must be 64: mapped onto the LO/HI word pairs
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                wb_adr_i,
  input  logic [31:0]               wb_dat_i,
  output logic [31:0]               wb_dat_o,
  input  logic                      wb_we_i,
  input  logic [3:0]                wb_sel_i,
  input  logic                      wb_cyc_i,
  input  logic                      wb_stb_i,
  output logic                      wb_ack_o,
  output logic                      irq_o,
  output logic                      htif_reset,
  output logic                      htif_pcr_req_valid,
  input  logic                      htif_pcr_req_ready,
  output logic                      htif_pcr_req_rw,
  output logic [CSR_ADDR_WIDTH-1:0] htif_pcr_req_addr,
  output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
  input  logic                      htif_pcr_resp_valid,
  output logic                      htif_pcr_resp_ready,
  input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state;
  logic [CSR_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]               wdata_lo, wdata_hi, rdata_lo, rdata_hi;
  logic                      rw_q, irq_en_q, done_q, timeout_q;
  logic [15:0]               cnt;

  logic        wb_req, wr_fire, wr_ctrl, go, clr_done, busy, cnt_hit;
  logic [2:0]  reg_sel;
  logic [15:0] cnt_inc;
  logic [31:0] rd_mux;
  logic        unused_ok;

  // Byte lanes and the address bits outside [4:2] carry no meaning here.
  assign unused_ok = ^{wb_sel_i, wb_adr_i[7:5], wb_adr_i[1:0]};

  assign wb_req   = wb_cyc_i & wb_stb_i;
  assign reg_sel  = wb_adr_i[4:2];
  // Writes take effect on the edge that closes the ack cycle.
  assign wr_fire  = wb_req & wb_ack_o & wb_we_i;
  assign wr_ctrl  = wr_fire & (reg_sel == 3'd3);
  assign go       = wr_ctrl & wb_dat_i[0];
  assign clr_done = wr_ctrl & wb_dat_i[3];
  assign busy     = (state != S_IDLE);
  assign cnt_hit  = (cnt == CNT_LAST);
  assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Request fields come straight from registers that are frozen while busy,
  // so they cannot change while req_valid is up.
  assign htif_pcr_req_rw   = rw_q;
  assign htif_pcr_req_addr = addr_q;
  assign htif_pcr_req_data = {wdata_hi, wdata_lo};
  assign irq_o             = done_q & irq_en_q;

  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      3'd0: rd_mux = 32'(addr_q);
      3'd1: rd_mux = wdata_lo;
      3'd2: rd_mux = wdata_hi;
      3'd3: rd_mux = {27'd0, rw_q, timeout_q, irq_en_q, done_q, busy};
      3'd4: rd_mux = rdata_lo;
      3'd5: rd_mux = rdata_hi;
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    htif_reset <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      wb_ack_o            <= 1'b0;
      wb_dat_o            <= 32'd0;
      addr_q              <= '0;
      wdata_lo            <= 32'd0;
      wdata_hi            <= 32'd0;
      rdata_lo            <= 32'd0;
      rdata_hi            <= 32'd0;
      rw_q                <= 1'b0;
      irq_en_q            <= 1'b0;
      done_q              <= 1'b0;
      timeout_q           <= 1'b0;
      cnt                 <= 16'd0;
      htif_pcr_req_valid  <= 1'b0;
      htif_pcr_resp_ready <= 1'b0;
    end else begin
      wb_ack_o <= wb_req & ~wb_ack_o;
      if (wb_req & ~wb_ack_o) wb_dat_o <= rd_mux;

      if (wr_fire && !busy) begin
        case (reg_sel)
          3'd0: addr_q   <= wb_dat_i[CSR_ADDR_WIDTH-1:0];
          3'd1: wdata_lo <= wb_dat_i;
          3'd2: wdata_hi <= wb_dat_i;
          default: ;
        endcase
      end

      if (wr_ctrl)  irq_en_q <= wb_dat_i[2];
      // Completion below is assigned later, so a same-cycle set beats clr_done.
      if (clr_done) done_q <= 1'b0;

      case (state)
        S_IDLE: begin
          if (go) begin
            rw_q               <= wb_dat_i[1];
            done_q             <= 1'b0;
            timeout_q          <= 1'b0;
            cnt                <= 16'd0;
            htif_pcr_req_valid <= 1'b1;
            state              <= S_REQ;
          end
        end
        S_REQ: begin
          cnt <= cnt_inc;
          if (htif_pcr_req_ready) begin
            cnt                 <= 16'd0;
            htif_pcr_req_valid  <= 1'b0;
            htif_pcr_resp_ready <= 1'b1;
            state               <= S_RESP;
          end else if (cnt_hit) begin
            htif_pcr_req_valid <= 1'b0;
            timeout_q          <= 1'b1;
            done_q             <= 1'b1;
            state              <= S_IDLE;
          end
        end
        S_RESP: begin
          cnt <= cnt_inc;
          if (htif_pcr_resp_valid) begin
            rdata_lo            <= htif_pcr_resp_data[31:0];
            rdata_hi            <= htif_pcr_resp_data[63:32];
            htif_pcr_resp_ready <= 1'b0;
            done_q              <= 1'b1;
            state               <= S_IDLE;
          end else if (cnt_hit) begin
            htif_pcr_resp_ready <= 1'b0;
            timeout_q           <= 1'b1;
            done_q              <= 1'b1;
            state               <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_wb_htif_bridge.sv
module tb_vscale_wb_htif_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;
  logic [3:0]  wb_sel_i;
  logic        irq_o, htif_reset;
  logic        htif_pcr_req_valid, htif_pcr_req_ready, htif_pcr_req_rw;
  logic [11:0] htif_pcr_req_addr;
  logic [63:0] htif_pcr_req_data;
  logic        htif_pcr_resp_valid, htif_pcr_resp_ready;
  logic [63:0] htif_pcr_resp_data;

  vscale_wb_htif_bridge #(.CSR_ADDR_WIDTH(12), .HTIF_PCR_WIDTH(64), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i),
    .wb_sel_i(wb_sel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_ack_o(wb_ack_o),
    .irq_o(irq_o), .htif_reset(htif_reset),
    .htif_pcr_req_valid(htif_pcr_req_valid), .htif_pcr_req_ready(htif_pcr_req_ready),
    .htif_pcr_req_rw(htif_pcr_req_rw), .htif_pcr_req_addr(htif_pcr_req_addr),
    .htif_pcr_req_data(htif_pcr_req_data),
    .htif_pcr_resp_valid(htif_pcr_resp_valid), .htif_pcr_resp_ready(htif_pcr_resp_ready),
    .htif_pcr_resp_data(htif_pcr_resp_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- CSR-file stub ----------------
  logic [63:0] csr_mem [0:4095];
  int          stub_delay = 0;
  bit          stub_ready_en = 1'b1;
  int          req_count = 0;
  logic [11:0] last_addr;
  logic        last_rw;
  logic [63:0] last_data;
  bit          resp_rdy_dropped = 1'b0;

  initial begin : stub
    bit fire_req, fire_resp, rst_seen, pend;
    int cnt;
    logic [63:0] pend_data;
    htif_pcr_req_ready  = 1'b0;
    htif_pcr_resp_valid = 1'b0;
    htif_pcr_resp_data  = 64'd0;
    pend = 1'b0; cnt = 0; pend_data = 64'd0;
    forever begin
      @(negedge clk);
      fire_req  = htif_pcr_req_valid && htif_pcr_req_ready;
      fire_resp = htif_pcr_resp_valid && htif_pcr_resp_ready;
      rst_seen  = reset;
      if (pend && !htif_pcr_resp_ready) resp_rdy_dropped = 1'b1;
      @(posedge clk); #1;
      if (rst_seen) begin
        pend = 1'b0;
        htif_pcr_resp_valid = 1'b0;
      end else begin
        if (fire_resp) begin
          htif_pcr_resp_valid = 1'b0;
          pend = 1'b0;
        end
        if (fire_req) begin
          req_count++;
          last_addr = htif_pcr_req_addr;
          last_rw   = htif_pcr_req_rw;
          last_data = htif_pcr_req_data;
          pend_data = csr_mem[last_addr];          // CSR file returns the pre-write value
          if (last_rw) csr_mem[last_addr] = last_data;
          else if (last_addr == 12'h780) csr_mem[last_addr] = 64'd0;  // to_host clears on read
          pend = 1'b1;
          cnt  = stub_delay;
        end
        if (pend && !htif_pcr_resp_valid) begin
          if (cnt == 0) begin
            htif_pcr_resp_valid = 1'b1;
            htif_pcr_resp_data  = pend_data;
          end else cnt--;
        end
      end
      htif_pcr_req_ready = stub_ready_en;
    end
  end

  // ---------------- Wishbone master ----------------
  task automatic wb_cycle(input logic [2:0] off, input logic we, input logic [31:0] d,
                          output logic [31:0] q);
    int n;
    wb_adr_i = {3'b000, off, 2'b00};
    wb_we_i  = we;
    wb_dat_i = d;
    wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!wb_ack_o && n < 16);
    if (!wb_ack_o) check("wb_ack_timeout", 64'd0, 64'd1);
    q = wb_dat_o;
    @(posedge clk); #1;     // ack-closing edge: write side effect lands here
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    wb_cycle(off, 1'b1, d, dummy);
  endtask

  task automatic wb_read(input logic [2:0] off, output logic [31:0] q);
    wb_cycle(off, 1'b0, 32'd0, q);
  endtask

  task automatic wait_done(output logic [31:0] st);
    int n;
    n = 0;
    do begin
      wb_read(3'd3, st); n++;
    end while (!st[1] && n < 1500);
    if (!st[1]) check("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- register-map vector table ----------------
  typedef struct {
    logic [2:0]  off;
    logic [31:0] wr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  // High-level model of the CSR file contents as the bridge should see them.
  logic [63:0] model_mem [int];

  initial begin : main
    logic [31:0] q, st, lo0, hi0;
    int n, rc0;

    reset = 1'b1;
    wb_adr_i = 8'd0; wb_dat_i = 32'd0; wb_we_i = 1'b0; wb_sel_i = 4'd0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    for (int i = 0; i < 4096; i++) csr_mem[i] = 64'd0;

    vecs[0]  = '{3'd0, 32'hFFFF_F780, 32'h0000_0780};
    vecs[1]  = '{3'd1, 32'hA5A5_5A5A, 32'hA5A5_5A5A};
    vecs[2]  = '{3'd2, 32'h0123_4567, 32'h0123_4567};
    vecs[3]  = '{3'd3, 32'h0000_0004, 32'h0000_0004};
    vecs[4]  = '{3'd3, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{3'd5, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9]  = '{3'd0, 32'h0000_0ABC, 32'h0000_0ABC};
    vecs[10] = '{3'd3, 32'h0000_0008, 32'h0000_0000};

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("htif_reset_first_cycle", 64'(htif_reset), 64'd1);
    check("rst_ack", 64'(wb_ack_o), 64'd0);
    check("rst_irq", 64'(irq_o), 64'd0);
    check("rst_req_valid", 64'(htif_pcr_req_valid), 64'd0);
    check("rst_resp_ready", 64'(htif_pcr_resp_ready), 64'd0);
    @(posedge clk); #1;
    check("htif_reset_released", 64'(htif_reset), 64'd0);
    for (int i = 0; i < 8; i++) begin
      wb_read(3'(i), q);
      check($sformatf("rst_reg%0d", i), 64'(q), 64'd0);
    end

    // ---- register map table ----
    for (int i = 0; i < 11; i++) begin
      wb_write(vecs[i].off, vecs[i].wr);
      wb_read(vecs[i].off, q);
      check($sformatf("vec%0d_off%0d", i, vecs[i].off), 64'(q), 64'(vecs[i].exp));
    end

    // ---- 1: write to_host, then read it back ----
    wb_write(3'd0, 32'h780);
    wb_write(3'd1, 32'h1234_5678);
    wb_write(3'd2, 32'h0);
    wb_write(3'd3, 32'h3);
    check("t1_req_valid_rise", 64'(htif_pcr_req_valid), 64'd1);
    check("t1_req_rw", 64'(htif_pcr_req_rw), 64'd1);
    @(posedge clk); #1;
    check("t1_req_valid_drop", 64'(htif_pcr_req_valid), 64'd0);
    @(posedge clk); #1;
    wb_read(3'd3, st);
    check("t1_status_done", 64'(st), 64'h12);
    check("t1_req_data", last_data, 64'h0000_0000_1234_5678);
    wb_write(3'd3, 32'h1);
    wait_done(st);
    wb_read(3'd4, q);
    check("t1_readback_lo", 64'(q), 64'h1234_5678);

    // ---- 2: core writes to_host, bridge reads it twice ----
    csr_mem[12'h780] = 64'hA5;
    wb_write(3'd3, 32'h1);
    wait_done(st);
    wb_read(3'd4, q);
    check("t2_first_read", 64'(q), 64'hA5);
    wb_write(3'd3, 32'h1);
    wait_done(st);
    wb_read(3'd4, q);
    check("t2_second_read", 64'(q), 64'h0);

    // ---- 3: request-phase timeout ----
    csr_mem[12'h020] = 64'h1111_2222_3333_4444;
    wb_write(3'd0, 32'h020);
    wb_write(3'd3, 32'h1);
    wait_done(st);
    wb_read(3'd4, lo0);
    wb_read(3'd5, hi0);
    stub_ready_en = 1'b0;
    @(posedge clk); #1;
    wb_write(3'd3, 32'h1);
    n = 0;
    while (htif_pcr_req_valid && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("t3_req_valid_cycles", 64'(n), 64'd1024);
    wb_read(3'd3, st);
    check("t3_status", 64'(st), 64'h0A);
    wb_read(3'd4, q);
    check("t3_rdata_lo_kept", 64'(q), 64'(lo0));
    wb_read(3'd5, q);
    check("t3_rdata_hi_kept", 64'(q), 64'(hi0));
    stub_ready_en = 1'b1;
    @(posedge clk); #1;

    // ---- 4: slow response ----
    csr_mem[12'h004] = 64'hDEAD_BEEF_0000_0001;
    stub_delay = 50;
    resp_rdy_dropped = 1'b0;
    wb_write(3'd0, 32'h004);
    wb_write(3'd3, 32'h1);
    wait_done(st);
    check("t4_resp_ready_held", 64'(resp_rdy_dropped), 64'd0);
    check("t4_status", 64'(st), 64'h02);
    wb_read(3'd5, q);
    check("t4_rdata_hi", 64'(q), 64'hDEAD_BEEF);
    wb_read(3'd4, q);
    check("t4_rdata_lo", 64'(q), 64'h1);
    stub_delay = 0;

    // ---- 5: interrupt ----
    wb_write(3'd3, 32'h5);
    wait_done(st);
    check("t5_irq_set", 64'(irq_o), 64'd1);
    wb_write(3'd3, 32'hC);
    check("t5_irq_clr", 64'(irq_o), 64'd0);
    wb_read(3'd3, st);
    check("t5_status_after_clr", 64'(st), 64'h04);
    wb_write(3'd3, 32'h1);
    wait_done(st);
    check("t5_irq_disabled", 64'(irq_o), 64'd0);

    // ---- randomized transactions against the model ----
    for (int i = 0; i < 4096; i++) csr_mem[i] = 64'd0;
    model_mem.delete();
    for (int t = 0; t < 40; t++) begin
      logic [11:0] a;
      logic        rw, ien, clr;
      logic [63:0] wd, exp_r;
      a   = ($urandom_range(0, 3) == 0) ? 12'h780 : 12'($urandom_range(0, 15));
      rw  = 1'($urandom_range(0, 1));
      ien = 1'($urandom_range(0, 1));
      clr = 1'($urandom_range(0, 1));
      wd  = {32'($urandom), 32'($urandom)};
      stub_delay = $urandom_range(0, 6);
      exp_r = model_mem.exists(int'(a)) ? model_mem[int'(a)] : 64'd0;
      if (rw) model_mem[int'(a)] = wd;
      else if (a == 12'h780) model_mem[int'(a)] = 64'd0;
      wb_write(3'd0, 32'(a));
      wb_write(3'd1, wd[31:0]);
      wb_write(3'd2, wd[63:32]);
      wb_write(3'd3, {28'd0, clr, ien, rw, 1'b1});
      wait_done(st);
      check($sformatf("rnd%0d_status", t), 64'(st), 64'({rw, 1'b0, ien, 1'b1, 1'b0}));
      check($sformatf("rnd%0d_irq", t), 64'(irq_o), 64'(ien));
      check($sformatf("rnd%0d_req", t), {last_rw, last_addr, last_data[31:0]}, {rw, a, wd[31:0]});
      wb_read(3'd4, q);
      check($sformatf("rnd%0d_rdata_lo", t), 64'(q), 64'(exp_r[31:0]));
      wb_read(3'd5, q);
      check($sformatf("rnd%0d_rdata_hi", t), 64'(q), 64'(exp_r[63:32]));
    end

    // ---- 6: writes while busy, then reset mid-RESP ----
    stub_delay = 200;
    wb_write(3'd0, 32'h010);
    rc0 = req_count;
    wb_write(3'd3, 32'h1);
    n = 0;
    while (req_count == rc0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("t6_req_issued", 64'(req_count), 64'(rc0 + 1));
    wb_write(3'd0, 32'h123);
    wb_write(3'd3, 32'h1);
    wb_read(3'd0, q);
    check("t6_addr_frozen", 64'(q), 64'h010);
    wb_read(3'd3, st);
    check("t6_busy", 64'(st[0]), 64'd1);
    check("t6_in_resp", 64'(htif_pcr_resp_ready), 64'd1);
    pulse_reset(1);
    check("t6_req_valid_after_rst", 64'(htif_pcr_req_valid), 64'd0);
    check("t6_resp_ready_after_rst", 64'(htif_pcr_resp_ready), 64'd0);
    check("t6_htif_reset", 64'(htif_reset), 64'd1);
    wb_read(3'd3, st);
    check("t6_status_after_rst", 64'(st), 64'd0);
    wb_read(3'd0, q);
    check("t6_addr_after_rst", 64'(q), 64'd0);
    repeat (250) @(posedge clk);
    #1;
    check("t6_no_second_req", 64'(req_count), 64'(rc0 + 1));
    wb_read(3'd3, st);
    check("t6_status_stays_idle", 64'(st), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
